multicycle_sequencer: RTL

//   Phase sequencer for the RV32 datapath (control_unit, reg_file, ALU, lab5_ram, instruction ROM).
//   - Owns the PC and walks each instruction through FETCH/DECODE/EXEC/MEM/WB phases.
//   - Gates the decoded RegWrite/MemRead/MemWrite so each strobe fires in exactly one phase.
//   - Resolves branches.
//   - Provides run / single-step / halt control, replacing the free-running PC+4 counter.

---
 rtl/multicycle_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the RV32 multicycle datapath: owns the PC, walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and emits one-phase registered strobes.
module multicycle_sequencer #(
    parameter int         PC_WIDTH = 11,
    parameter int         PC_STEP  = 4,
    parameter int         RESET_PC = 0,
    parameter int         MEM_WAIT = 1,
    parameter logic [6:0] HALT_OP  = 7'h7f
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                step,
    input  logic [6:0]          opcode,
    input  logic                reg_write,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                branch,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] pc_offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic                ir_load,
    output logic                rf_wren,
    output logic                ram_rden,
    output logic                ram_wren,
    output logic                busy,
    output logic                halted,
    output logic [15:0]         instr_count
);

    localparam int            WAIT_W   = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [PC_WIDTH-1:0] STEP_V  = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] RESET_V = PC_WIDTH'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         count_q, count_d;
    logic                cls_rw_q, cls_rw_d;
    logic                cls_mr_q, cls_mr_d;
    logic                cls_mw_q, cls_mw_d;
    logic                cls_br_q, cls_br_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                ir_load_q, ir_load_d;
    logic                rf_wren_q, rf_wren_d;
    logic                ram_rden_q, ram_rden_d;
    logic                ram_wren_q, ram_wren_d;
    logic                retire;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        cls_rw_d = cls_rw_q;
        cls_mr_d = cls_mr_q;
        cls_mw_d = cls_mw_q;
        cls_br_d = cls_br_q;
        wait_d   = wait_q;
        retire   = 1'b0;

        unique case (state_q)
            S_IDLE:   if (run || step) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == HALT_OP) begin
                    state_d = S_HALT;
                end else begin
                    cls_rw_d = reg_write;
                    cls_mr_d = mem_read;
                    cls_mw_d = mem_write;
                    cls_br_d = branch;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_br_q) begin
                    retire = 1'b1;
                end else if (cls_mr_q || cls_mw_q) begin
                    state_d = S_MEM;
                    wait_d  = WAIT_W'(MEM_WAIT - 1);
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (wait_q == '0) begin
                    if (cls_mr_q) state_d = S_WB;
                    else          retire  = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_WB:     retire = 1'b1;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // Branch only retires from EXEC, so zero is the EXEC-cycle value here.
        if (retire) begin
            pc_d    = (cls_br_q && zero) ? pc_q + pc_offset : pc_q + STEP_V;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_d = run ? S_FETCH : S_IDLE;
        end

        // Strobes are decoded from the next state so they come straight from flops.
        ir_load_d  = (state_d == S_DECODE);
        rf_wren_d  = (state_d == S_WB)  && cls_rw_q;
        ram_rden_d = (state_d == S_MEM) && cls_mr_q;
        ram_wren_d = (state_d == S_MEM) && cls_mw_q && !cls_mr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_V;
            count_q    <= '0;
            cls_rw_q   <= 1'b0;
            cls_mr_q   <= 1'b0;
            cls_mw_q   <= 1'b0;
            cls_br_q   <= 1'b0;
            wait_q     <= '0;
            ir_load_q  <= 1'b0;
            rf_wren_q  <= 1'b0;
            ram_rden_q <= 1'b0;
            ram_wren_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            cls_rw_q   <= cls_rw_d;
            cls_mr_q   <= cls_mr_d;
            cls_mw_q   <= cls_mw_d;
            cls_br_q   <= cls_br_d;
            wait_q     <= wait_d;
            ir_load_q  <= ir_load_d;
            rf_wren_q  <= rf_wren_d;
            ram_rden_q <= ram_rden_d;
            ram_wren_q <= ram_wren_d;
        end
    end

    assign pc          = pc_q;
    assign instr_count = count_q;
    assign ir_load     = ir_load_q;
    assign rf_wren     = rf_wren_q;
    assign ram_rden    = ram_rden_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted      = (state_q == S_HALT);

endmodule
